// File: rtl/memory_bus_arbiter.sv
// CPU/DMA arbiter for the 8-bit memory bus: fixed IDLE->ACCESS->COMPLETE sequence, map check, ack.
// Build option ARB_FIXED_PRIO_EN: CPU always wins ties (default is round-robin with burst limit).
module memory_bus_arbiter #(
  parameter logic [7:0]  ROM_TOP   = 8'h7F,
  parameter logic [7:0]  RW_TOP    = 8'hDF,
  parameter logic [7:0]  OUT_BASE  = 8'hE0,
  parameter logic [7:0]  IN_BASE   = 8'hF0,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_gnt,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata,
  output logic       cpu_err,
  input  logic       dma_req,
  input  logic       dma_we,
  input  logic [7:0] dma_addr,
  input  logic [7:0] dma_wdata,
  output logic       dma_gnt,
  output logic       dma_ack,
  output logic [7:0] dma_rdata,
  output logic       dma_err,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, COMPLETE} state_t;

  state_t     state, state_next;
  logic       owner;            // 0 = CPU, 1 = DMA
  logic       lat_we;
  logic [7:0] lat_addr, lat_wdata;
  logic       cpu_elig, dma_elig, grant, winner;
  logic       legal_rd, legal_wr, legal;

`ifdef ARB_FIXED_PRIO_EN
`else
  localparam int unsigned    BW        = $clog2(BURST_MAX + 1);
  localparam logic [BW-1:0]  BURST_LIM = BW'(BURST_MAX);
  logic          last_owner;
  logic [BW-1:0] burst_cnt;
`endif

  assign cpu_elig = cpu_req & ~cpu_ack;
  assign dma_elig = dma_req & ~dma_ack;

  assign legal_rd = (lat_addr <= RW_TOP) || (lat_addr >= IN_BASE);
  assign legal_wr = ((lat_addr > ROM_TOP) && (lat_addr <= RW_TOP)) ||
                    ((lat_addr >= OUT_BASE) && (lat_addr < IN_BASE));
  assign legal    = lat_we ? legal_wr : legal_rd;

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    winner     = dma_elig;
    cpu_gnt    = 1'b0;
    dma_gnt    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    if (cpu_elig && dma_elig) begin
`ifdef ARB_FIXED_PRIO_EN
      winner = 1'b0;
`else
      // burst_cnt==0 only after reset: no burst in progress, so last_owner yields
      winner = ((burst_cnt != '0) && (burst_cnt < BURST_LIM)) ? last_owner : ~last_owner;
`endif
    end
    case (state)
      IDLE: begin
        if (cpu_elig || dma_elig) begin
          grant      = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = COMPLETE;
        cpu_gnt    = ~owner;
        dma_gnt    = owner;
        mem_addr   = lat_addr;
        mem_wdata  = lat_wdata;
        mem_we     = lat_we & legal_wr;
      end
      COMPLETE: begin
        state_next = IDLE;
        cpu_gnt    = ~owner;
        dma_gnt    = owner;
        mem_addr   = lat_addr;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_err   <= 1'b0;
      dma_err   <= 1'b0;
`ifdef ARB_FIXED_PRIO_EN
`else
      last_owner <= 1'b1;
      burst_cnt  <= '0;
`endif
    end else begin
      state   <= state_next;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (grant) begin
        owner     <= winner;
        lat_we    <= winner ? dma_we    : cpu_we;
        lat_addr  <= winner ? dma_addr  : cpu_addr;
        lat_wdata <= winner ? dma_wdata : cpu_wdata;
`ifdef ARB_FIXED_PRIO_EN
`else
        last_owner <= winner;
        if (winner == last_owner) begin
          if (burst_cnt != BURST_LIM) burst_cnt <= burst_cnt + 1'b1;
        end else begin
          burst_cnt <= BW'(1);
        end
`endif
      end
      if (state == COMPLETE) begin
        if (owner) begin
          dma_ack   <= 1'b1;
          dma_rdata <= (legal && !lat_we) ? mem_rdata : 8'h00;
          dma_err   <= ~legal;
        end else begin
          cpu_ack   <= 1'b1;
          cpu_rdata <= (legal && !lat_we) ? mem_rdata : 8'h00;
          cpu_err   <= ~legal;
        end
      end
    end
  end

endmodule
